wb_arb2_i2c: RTL and testbench

- Two-master to one-slave Wishbone arbiter. It shares the single WB slave port of the I2C master core between two requesters, for example a CPU bridge and a hardware init sequencer.
- Round-robin, cycle-granular: once granted, a master owns the slave until it drops cyc.
- A bus watchdog terminates stalled cycles with err.
- Sits directly in front of the I2C core's WB port in the I2C/WB subsystem.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_arb_wdog.sv | 39 +++
 rtl/wb_arb2_i2c.sv | 162 ++++++++++++++++
 tb/tb_wb_arb2_i2c.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter in front of the I2C core.
package wb_arb_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  function automatic logic [1:0] gnt_of(arb_state_e s);
    logic [1:0] g;
    case (s)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Bus watchdog: counts stalled strobe cycles and flags one expire cycle at TIMEOUT_CYC.
module wb_arb_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_s;
      assign unused_s = ^{clk, rst, en, clr};
      assign expire   = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
      logic [CW-1:0] cnt_r;

      // Stall counter; saturates at the limit, cleared whenever the stall is broken
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_r <= '0;
        end else if (clr || !en) begin
          cnt_r <= '0;
        end else if (cnt_r != LIMIT) begin
          cnt_r <= cnt_r + CW'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end

      assign expire = en && (cnt_r == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/wb_arb2_i2c.sv
// Two-master round-robin Wishbone arbiter sharing the I2C core's slave port.
// Ownership is per cycle (cyc); a watchdog aborts stalled strobes with err.
module wb_arb2_i2c
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic              s_we_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  arb_state_e state_r, state_s;
  owner_t     last_r, last_s;
  logic       wd_en_s, wd_clr_s, expire_s;

  assign wd_en_s  = !s_ack_i && (((state_r == OWN0) && m0_stb_i) ||
                                 ((state_r == OWN1) && m1_stb_i));
  assign wd_clr_s = (state_s != state_r);

  wb_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .en     (wd_en_s),
    .clr    (wd_clr_s),
    .expire (expire_s)
  );

  // State and last-owner registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Next-state arbitration; an expired owner goes to IDLE so a waiting peer wins next
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_s = (last_r == 1'b1) ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_s = OWN0;
        end else if (m1_cyc_i) begin
          state_s = OWN1;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        if (expire_s) begin
          state_s = IDLE;
        end else if (m0_cyc_i) begin
          state_s = OWN0;
        end else if (m1_cyc_i) begin
          state_s = OWN1;
        end else begin
          state_s = IDLE;
        end
        if (state_s != OWN0) begin
          last_s = 1'b0;
        end else begin
          last_s = last_r;
        end
      end
      OWN1: begin
        if (expire_s) begin
          state_s = IDLE;
        end else if (m1_cyc_i) begin
          state_s = OWN1;
        end else if (m0_cyc_i) begin
          state_s = OWN0;
        end else begin
          state_s = IDLE;
        end
        if (state_s != OWN1) begin
          last_s = 1'b1;
        end else begin
          last_s = last_r;
        end
      end
      default: begin
        state_s = IDLE;
        last_s  = last_r;
      end
    endcase
  end

  // Slave/master routing from the registered owner; cyc/stb are cut in the expire cycle
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_r)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i && !expire_s;
        s_stb_o  = m0_stb_i && !expire_s;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = expire_s;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i && !expire_s;
        s_stb_o  = m1_stb_i && !expire_s;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = expire_s;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  assign gnt_o = gnt_of(state_r);

endmodule

// File: tb/tb_wb_arb2_i2c.sv
// Directed bench for wb_arb2_i2c with a short watchdog (TIMEOUT_CYC = 4).
module tb_wb_arb2_i2c;

  logic       clk;
  logic       rst;
  logic [2:0] m0_adr, m1_adr, s_adr;
  logic [7:0] m0_wd, m1_wd, m0_rd, m1_rd, s_wd, s_rd;
  logic       m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic       m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic       s_we, s_stb, s_cyc, s_ack;
  logic [1:0] gnt;
  int         total = 0;
  int         bad = 0;

  wb_arb2_i2c #(.ADDR_W(3), .DATA_W(8), .TIMEOUT_CYC(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_dat_o(m0_rd), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_dat_o(m1_rd), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_rd), .s_we_o(s_we),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = 3'd0; m0_wd = 8'd0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = 3'd0; m1_wd = 8'd0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_rd = 8'd0; s_ack = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    total++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin bad++; $display("FAIL rst_sctl got=%b exp=000", {s_cyc, s_stb, s_we}); end
    total++; if ({s_adr, s_wd} !== 11'd0) begin bad++; $display("FAIL rst_sbus got=%h exp=0", {s_adr, s_wd}); end
    total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin bad++; $display("FAIL rst_mresp got=%b exp=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    total++; if ({m0_rd, m1_rd} !== 16'd0) begin bad++; $display("FAIL rst_mdat got=%h exp=0", {m0_rd, m1_rd}); end
  endtask

  task automatic test_m0_write();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 3'h2; m0_wd = 8'hA5;
    #1;
    total++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin bad++; $display("FAIL wr_pregnt got=%b/%b exp=00/0", gnt, s_cyc); end
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
    total++; if (s_adr !== 3'h2 || s_wd !== 8'hA5 || s_we !== 1'b1) begin bad++; $display("FAIL wr_bus got=%h/%h/%b exp=2/a5/1", s_adr, s_wd, s_we); end
    total++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL wr_ctl got=%b%b%b exp=110", s_cyc, s_stb, m0_ack); end
    s_ack = 1'b1;
    #1;
    total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL wr_ack got=%b%b exp=10", m0_ack, m1_ack); end
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL wr_release got=%b exp=00", gnt); end
  endtask

  task automatic test_contention();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL ct_first got=%b exp=01", gnt); end
    s_ack = 1'b1;
    #1;
    total++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin bad++; $display("FAIL ct_ack0 got=%b%b exp=10", m0_ack, m1_ack); end
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    total++; if (gnt !== 2'b01 || s_cyc !== 1'b0) begin bad++; $display("FAIL ct_drop got=%b/%b exp=01/0", gnt, s_cyc); end
    step();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL ct_handover got=%b exp=10", gnt); end
    s_ack = 1'b1;
    #1;
    total++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin bad++; $display("FAIL ct_ack1 got=%b%b exp=01", m0_ack, m1_ack); end
    step();
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL ct_idle got=%b exp=00", gnt); end
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL ct_alternate got=%b exp=01", gnt); end
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] rdv [3];
    rdv[0] = 8'h11; rdv[1] = 8'h22; rdv[2] = 8'h33;
    apply_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 3'h4;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rd = rdv[i]; s_ack = 1'b1;
      #1;
      total++; if (m1_rd !== rdv[i] || m1_ack !== 1'b1) begin bad++; $display("FAIL b2b_rd%0d got=%h/%b exp=%h/1", i, m1_rd, m1_ack, rdv[i]); end
      total++; if (gnt !== 2'b10 || m0_ack !== 1'b0 || m0_rd !== 8'h00) begin bad++; $display("FAIL b2b_own%0d got=%b/%b/%h exp=10/0/00", i, gnt, m0_ack, m0_rd); end
      step();
      s_ack = 1'b0;
      step();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL b2b_hold got=%b exp=10", gnt); end
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL b2b_m0gnt got=%b exp=01", gnt); end
    clear_inputs();
    step();
  endtask

  task automatic test_watchdog();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (m0_err !== 1'b0 || s_cyc !== 1'b1 || gnt !== 2'b01) begin bad++; $display("FAIL wd_stall%0d got=%b/%b/%b exp=0/1/01", i, m0_err, s_cyc, gnt); end
      step();
    end
    #1;
    total++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin bad++; $display("FAIL wd_err got=%b%b exp=10", m0_err, m1_err); end
    total++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL wd_cut got=%b%b exp=00", s_cyc, s_stb); end
    step();
    total++; if (gnt !== 2'b00 || m0_err !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b/%b exp=00/0", gnt, m0_err); end
    step();
    total++; if (gnt !== 2'b10 || s_cyc !== 1'b1) begin bad++; $display("FAIL wd_m1gnt got=%b/%b exp=10/1", gnt, s_cyc); end
    clear_inputs();
    step();
  endtask

  task automatic test_ack_at_timeout();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    s_ack = 1'b1;
    #1;
    total++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || s_cyc !== 1'b1) begin bad++; $display("FAIL at_ack got=%b%b%b exp=101", m0_ack, m0_err, s_cyc); end
    step();
    s_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (gnt !== 2'b01 || m0_err !== 1'b0) begin bad++; $display("FAIL at_keep%0d got=%b/%b exp=01/0", i, gnt, m0_err); end
      step();
    end
    #1;
    total++; if (m0_err !== 1'b1) begin bad++; $display("FAIL at_rearm got=%b exp=1", m0_err); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 3'h6; m1_wd = 8'h3C;
    step();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL rm_own got=%b exp=10", gnt); end
    rst = 1'b1;
    step();
    s_rd = 8'h5A; s_ack = 1'b1;
    #1;
    total++; if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin bad++; $display("FAIL rm_idle got=%b/%b%b exp=00/00", gnt, s_cyc, s_stb); end
    total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000 || m1_rd !== 8'h00) begin bad++; $display("FAIL rm_noresp got=%b/%h exp=0000/00", {m0_ack, m0_err, m1_ack, m1_err}, m1_rd); end
    s_ack = 1'b0; rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_m0first got=%b exp=01", gnt); end
    clear_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_m0_write();
    test_contention();
    test_back_to_back();
    test_watchdog();
    test_ack_at_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
